inc_arbiter: RTL

//   Shares one 16-bit incrementer (inc) among NUM_REQ requesters, e.g. PC

---
 rtl/inc_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/inc_arbiter.sv
// inc_arbiter: round-robin arbiter sharing one registered 16-bit incrementer
// among NUM_REQ requesters with a req/gnt/rsp handshake, one op per 3 cycles.
module inc_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_operand,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [15:0]            rsp_data,
    output logic                   rsp_ovf,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   ptr, idx, win;
    logic               found;
    logic [15:0]        op_reg, res_reg, inc_out;
    logic               ovf_reg;
    logic [NUM_REQ-1:0] one;

    assign one     = {{(NUM_REQ-1){1'b0}}, 1'b1};
    assign inc_out = op_reg + 16'd1;

    // first requester at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[IDX_W'((int'(ptr) + k) % NUM_REQ)]) begin
                win   = IDX_W'((int'(ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = (state == IDLE) ? (|req ? EXEC : IDLE) :
                   (state == EXEC) ? DONE : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            idx     <= '0;
            op_reg  <= '0;
            res_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            if (state == IDLE && |req) begin
                idx    <= win;
                op_reg <= req_operand[16*win +: 16];
            end
            if (state == EXEC) begin
                res_reg <= inc_out;
                ovf_reg <= &op_reg;
            end
            if (state == DONE)
                ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

    assign gnt       = (state == EXEC) ? one << idx : '0;
    assign rsp_valid = (state == DONE) ? one << idx : '0;
    assign rsp_data  = (state == DONE) ? res_reg : 16'd0;
    assign rsp_ovf   = (state == DONE) && ovf_reg;
    assign busy      = (state != IDLE);
endmodule
